// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with almost-full/empty thresholds and sticky error flags.
// Define FIFO_FWFT_EN to get a first-word-fall-through read port instead of a registered one.
module sync_fifo_param #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned AF_LEVEL = DEPTH - 1,
   parameter int unsigned AE_LEVEL = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       wr_en,
   input  logic [DATA_W-1:0]          wr_data,
   input  logic                       rd_en,
   output logic [DATA_W-1:0]          rd_data,
   output logic                       rd_valid,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic [$clog2(DEPTH):0]     count,
   input  logic                       err_clr,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int unsigned AW = $clog2(DEPTH);

   localparam logic [AW:0] DepthCnt = DEPTH[AW:0];
   localparam logic [AW:0] AfLvl    = AF_LEVEL[AW:0];
   localparam logic [AW:0] AeLvl    = AE_LEVEL[AW:0];

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          unf_q, unf_d;
   logic          rd_acc, wr_acc;

   assign full         = (count_q == DepthCnt);
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= AfLvl);
   assign almost_empty = (count_q <= AeLvl);
   assign count        = count_q;
   assign overflow     = ovf_q;
   assign underflow    = unf_q;

   // A write into a full FIFO still fits when a read frees a slot on the same edge.
   assign rd_acc = rd_en && !empty;
   assign wr_acc = wr_en && (!full || rd_acc);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (rd_acc) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      unique case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + (AW + 1)'(1);
         2'b01:   count_d = count_q - (AW + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Clear wins over a same-cycle rejection.
   always_comb begin
      ovf_d = ovf_q;
      unf_d = unf_q;
      if (err_clr) begin
         ovf_d = 1'b0;
         unf_d = 1'b0;
      end else begin
         if (wr_en && !wr_acc) begin
            ovf_d = 1'b1;
         end
         if (rd_en && !rd_acc) begin
            unf_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   // Storage is deliberately not reset; stale words are never exposed.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

`ifdef FIFO_FWFT_EN
   assign rd_data  = mem_q[rd_ptr_q];
   assign rd_valid = !empty;
`else
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              rd_valid_q, rd_valid_d;

   always_comb begin
      rd_data_d  = rd_data_q;
      rd_valid_d = rd_acc;
      if (rd_acc) begin
         rd_data_d = mem_q[rd_ptr_q];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
`endif

endmodule
